if_scratch_filler: RTL and testbench
====================================

# if_scratch_filler

Write-side controller for the input-feature (IF) circular scratchpad. It drains words from the IF FIFO into the scratchpad and maintains the `start_ptr`/`end_ptr` pair consumed by the IF distance calculator. It also keeps an explicit occupancy count, so a full buffer is distinguished from an empty one. It sits between the IF FIFO (upstream) and the IF scratchpad / distance calculator / convolution controller (downstream).

## Interface
- `ADDR_LEN`, 4: scratchpad address width.
- `SCRATCH_DEPTH`, 16: number of scratchpad entries; must satisfy 2 ≤ SCRATCH_DEPTH ≤ 2^ADDR_LEN.
- `SCRATCH_WIDTH`, 16: data word width.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: pulse that begins a fill burst; sampled only in IDLE.
- `fill_len` in ADDR_LEN+1: number of words to write in the burst; latched on accepted `start`.
- `fifo_empty` in 1: IF FIFO empty flag.
- `fifo_rdata` in SCRATCH_WIDTH: FIFO head word (first-word-fall-through; valid whenever `!fifo_empty`).
- `fifo_ren` out 1: pops the FIFO head this cycle.
- `sp_wen` out 1: scratchpad write enable.
- `sp_waddr` out ADDR_LEN: scratchpad write address.
- `sp_wdata` out SCRATCH_WIDTH: scratchpad write data.
- `release_en` in 1: consumer frees entries this cycle.
- `release_cnt` in ADDR_LEN+1: number of entries freed.
- `start_ptr` out ADDR_LEN: oldest valid entry.
- `end_ptr` out ADDR_LEN: next write address.
- `occupancy` out ADDR_LEN+1: number of valid entries, 0..SCRATCH_DEPTH.
- `full` out 1: `occupancy == SCRATCH_DEPTH`.
- `busy` out 1: asserted in FILL.
- `done` out 1: one-cycle pulse at burst completion.

## Operation
- **FSM** has three states: IDLE, FILL, DONE.
  - IDLE: `start` latches `fill_len` into `remaining`. The next state is FILL if `fill_len != 0`, otherwise DONE.
  - FILL: the block writes whenever `!fifo_empty && !full`. When `remaining == 1` and a write occurs, the next state is DONE.
  - DONE: `done = 1`, then the FSM returns unconditionally to IDLE.
  - `start` outside IDLE is ignored.
- **Write cycle:** `fifo_ren = sp_wen = 1`, `sp_waddr = end_ptr`, `sp_wdata = fifo_rdata`, `end_ptr` advances by 1, and `remaining` decrements by 1. All write outputs are combinational from registered state plus `fifo_empty`.
- **Pointer arithmetic:** modulo SCRATCH_DEPTH. Increment wraps from SCRATCH_DEPTH-1 to 0. Release computes `start_ptr + n`, subtracting SCRATCH_DEPTH when the sum is ≥ SCRATCH_DEPTH. All sums are computed at ADDR_LEN+1 bits.
- **Release:** the effective count is `n = min(release_cnt, occupancy)`, using the registered occupancy. `start_ptr` advances by n.
- **Occupancy update each cycle:** `occupancy + wr − n`, where `wr` is 1 on a write cycle. Write and release in the same cycle are both applied.
- **Full gating:** `full` is evaluated on registered occupancy. A release in the same cycle does not unblock a write until the next cycle.
- **Invariant:** `occupancy` equals the distance from `start_ptr` to `end_ptr`, except when full, where the distance is 0 and occupancy is SCRATCH_DEPTH.
- **Reset values:**
  - `start_ptr`, `end_ptr`, `occupancy` and `remaining` reset to 0.
  - The FSM resets to IDLE.
  - `busy`, `done`, `full`, `fifo_ren` and `sp_wen` reset to 0.
  - `sp_waddr` resets to 0; `sp_wdata` follows `fifo_rdata`.
- **Reset mid-burst:** aborts immediately with no `done` pulse. Data already written is discarded, because the pointers are cleared.

## Timing
- `start` is accepted at edge 0, the FSM is in FILL from cycle 1, and the earliest write occurs in cycle 1.
- An N-word burst with no stalls writes in cycles 1..N. `done` is high in cycle N+1, and IDLE resumes at cycle N+2.
- With `fill_len = 0`, `done` is high in cycle 1 and no writes occur.
- Each cycle with `fifo_empty` or `full` adds exactly one stall cycle, during which `fifo_ren = sp_wen = 0`.
- Pointer, occupancy and `full` updates are visible the cycle after the causing edge.
- Throughput is one word per cycle.

## Test plan
- **Reset and basic fill:** hold `rst = 0`, release it, FIFO holds 3 words (A, B, C), `start` with `fill_len = 3`.
  - Writes go to addresses 0, 1, 2 in cycles 1–3 with data A, B, C.
  - `done` is high in cycle 4.
  - Result: `end_ptr = 3`, `occupancy = 3`, `start_ptr = 0`.
- **FIFO underflow stall:** `fill_len = 4` with `fifo_empty = 1` in cycles 2–3.
  - Writes occur in cycles 1, 4, 5 and 6; `done` is high in cycle 7.
  - `busy` stays high throughout cycles 1–6.
- **Full and wrap-around:** DEPTH = 16, `fill_len = 16` from empty.
  - `full = 1` after the last write and `end_ptr = 0`.
  - A second burst of 2 stalls until `release_cnt = 5` is applied.
  - After the release: `start_ptr = 5`, `occupancy = 11`.
  - The following writes go to addresses 0 and 1.
- **Simultaneous write and release:** with `occupancy = 4`, a write and a release of 2 occur in the same cycle.
  - Next cycle: `occupancy = 3`, and both `start_ptr` and `end_ptr` have advanced.
- **Release clamp and wrap:** `start_ptr = 14`, `occupancy = 3`, `release_cnt = 7`.
  - Result: `start_ptr = 1`, `occupancy = 0`, `full = 0`.
- **Reset mid-burst:** assert `rst = 0` during cycle 2 of a 5-word burst.
  - All outputs immediately return to their reset values.
  - No `done` pulse occurs and no further writes occur.

Source files
------------

// File: rtl/if_scratch_filler.sv
`default_nettype none
// ============================================================================
//  Module      : if_scratch_filler
//  Description : Write-side controller for the input-feature circular
//                scratchpad. It drains words from a first-word-fall-through
//                FIFO into the scratchpad in bursts and maintains the
//                start/end pointer pair plus an explicit occupancy count.
//
//  Ports
//    clk, rst          : clock (rising edge), asynchronous active-low reset
//    start, fill_len   : burst request (sampled in IDLE) and its word count
//    fifo_empty/rdata  : FIFO status and head word
//    fifo_ren          : FIFO pop strobe
//    sp_wen/waddr/wdata: scratchpad write port
//    release_en/cnt    : consumer frees entries from the oldest end
//    start_ptr/end_ptr : oldest valid entry / next write address
//    occupancy, full   : valid entry count and full flag
//    busy, done        : burst in progress / one-cycle completion pulse
//
//  Revision    : 1.0 - initial release
// ============================================================================
module if_scratch_filler #(
    parameter int ADDR_LEN      = 4,
    parameter int SCRATCH_DEPTH = 16,
    parameter int SCRATCH_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [ADDR_LEN:0]        fill_len,
    input  logic                     fifo_empty,
    input  logic [SCRATCH_WIDTH-1:0] fifo_rdata,
    output logic                     fifo_ren,
    output logic                     sp_wen,
    output logic [ADDR_LEN-1:0]      sp_waddr,
    output logic [SCRATCH_WIDTH-1:0] sp_wdata,
    input  logic                     release_en,
    input  logic [ADDR_LEN:0]        release_cnt,
    output logic [ADDR_LEN-1:0]      start_ptr,
    output logic [ADDR_LEN-1:0]      end_ptr,
    output logic [ADDR_LEN:0]        occupancy,
    output logic                     full,
    output logic                     busy,
    output logic                     done
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_FILL = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam logic [ADDR_LEN:0]   c_DEPTH = (ADDR_LEN+1)'(SCRATCH_DEPTH);
    localparam logic [ADDR_LEN-1:0] c_LAST  = ADDR_LEN'(SCRATCH_DEPTH - 1);
    localparam logic [ADDR_LEN:0]   c_ONE   = (ADDR_LEN+1)'(1);

    logic [1:0]          r_state;
    logic [ADDR_LEN:0]   r_remaining;
    logic [ADDR_LEN-1:0] r_start_ptr;
    logic [ADDR_LEN-1:0] r_end_ptr;
    logic [ADDR_LEN:0]   r_occ;

    logic                w_full;
    logic                w_wr;
    logic [ADDR_LEN:0]   w_rel_n;
    logic [ADDR_LEN:0]   w_sp_sum;
    logic [ADDR_LEN-1:0] w_start_next;
    logic [ADDR_LEN-1:0] w_end_next;
    logic [ADDR_LEN:0]   w_occ_next;

    // Full is judged on registered occupancy only, so a release in the
    // same cycle unblocks writing one cycle later.
    assign w_full = (r_occ == c_DEPTH);
    assign w_wr   = (r_state == c_FILL) && !fifo_empty && !w_full;

    assign fifo_ren  = w_wr;
    assign sp_wen    = w_wr;
    assign sp_waddr  = r_end_ptr;
    assign sp_wdata  = fifo_rdata;
    assign start_ptr = r_start_ptr;
    assign end_ptr   = r_end_ptr;
    assign occupancy = r_occ;
    assign full      = w_full;
    assign busy      = (r_state == c_FILL);
    assign done      = (r_state == c_DONE);

    always_comb begin
        // Never release more entries than are currently valid.
        w_rel_n = '0;
        if (release_en) begin
            w_rel_n = (release_cnt < r_occ) ? release_cnt : r_occ;
        end

        // start_ptr < DEPTH and n <= DEPTH, so one conditional subtract
        // is enough to bring the sum back into range.
        w_sp_sum = {1'b0, r_start_ptr} + w_rel_n;
        if (w_sp_sum >= c_DEPTH) begin
            w_start_next = ADDR_LEN'(w_sp_sum - c_DEPTH);
        end else begin
            w_start_next = w_sp_sum[ADDR_LEN-1:0];
        end

        w_end_next = r_end_ptr;
        if (w_wr) begin
            w_end_next = (r_end_ptr == c_LAST) ? '0 : r_end_ptr + 1'b1;
        end

        w_occ_next = r_occ + {{ADDR_LEN{1'b0}}, w_wr} - w_rel_n;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_start_ptr <= '0;
            r_end_ptr   <= '0;
            r_occ       <= '0;
        end else begin
            r_start_ptr <= w_start_next;
            r_end_ptr   <= w_end_next;
            r_occ       <= w_occ_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= c_IDLE;
            r_remaining <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_remaining <= fill_len;
                        r_state     <= (fill_len != '0) ? c_FILL : c_DONE;
                    end
                end
                c_FILL: begin
                    if (w_wr) begin
                        r_remaining <= r_remaining - c_ONE;
                        if (r_remaining == c_ONE) begin
                            r_state <= c_DONE;
                        end
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_if_scratch_filler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_scratch_filler
//  Description : Self-checking bench for if_scratch_filler. Directed
//                scenarios followed by random traffic, all checked every
//                cycle against an arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_if_scratch_filler;

    localparam int AL = 4;
    localparam int D  = 16;
    localparam int W  = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AL:0]   fill_len;
    logic          fifo_empty;
    logic [W-1:0]  fifo_rdata;
    logic          fifo_ren;
    logic          sp_wen;
    logic [AL-1:0] sp_waddr;
    logic [W-1:0]  sp_wdata;
    logic          release_en;
    logic [AL:0]   release_cnt;
    logic [AL-1:0] start_ptr;
    logic [AL-1:0] end_ptr;
    logic [AL:0]   occupancy;
    logic          full;
    logic          busy;
    logic          done;

    if_scratch_filler #(
        .ADDR_LEN      (AL),
        .SCRATCH_DEPTH (D),
        .SCRATCH_WIDTH (W)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .fill_len    (fill_len),
        .fifo_empty  (fifo_empty),
        .fifo_rdata  (fifo_rdata),
        .fifo_ren    (fifo_ren),
        .sp_wen      (sp_wen),
        .sp_waddr    (sp_waddr),
        .sp_wdata    (sp_wdata),
        .release_en  (release_en),
        .release_cnt (release_cnt),
        .start_ptr   (start_ptr),
        .end_ptr     (end_ptr),
        .occupancy   (occupancy),
        .full        (full),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: burst phase (0 idle, 1 filling, 2 finished),
    // words left, pointers and occupancy as plain integers.
    int m_ph, m_rem, m_sp, m_ep, m_occ;

    task automatic check(input string tag, input logic [31:0] got, input int exp);
        n_vec++;
        if (got !== 32'(exp)) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_ph = 0; m_rem = 0; m_sp = 0; m_ep = 0; m_occ = 0;
    endtask

    // One clock cycle: drive inputs after the falling edge, compare every
    // output against the model, then advance the model across the rising edge.
    task automatic cyc(input bit st, input int len, input bit emp,
                       input bit rel, input int rc, input bit rv);
        int wr;
        int n;
        @(negedge clk);
        rst         = rv;
        start       = st;
        fill_len    = (AL+1)'(len);
        fifo_empty  = emp;
        fifo_rdata  = W'($urandom);
        release_en  = rel;
        release_cnt = (AL+1)'(rc);
        if (!rv) model_reset();
        #1;
        wr = (m_ph == 1 && !emp && m_occ < D) ? 1 : 0;
        check("sp_wen",    sp_wen,    wr);
        check("fifo_ren",  fifo_ren,  wr);
        check("sp_waddr",  sp_waddr,  m_ep);
        check("sp_wdata",  sp_wdata,  int'(fifo_rdata));
        check("start_ptr", start_ptr, m_sp);
        check("end_ptr",   end_ptr,   m_ep);
        check("occupancy", occupancy, m_occ);
        check("full",      full,      (m_occ == D) ? 1 : 0);
        check("busy",      busy,      (m_ph == 1) ? 1 : 0);
        check("done",      done,      (m_ph == 2) ? 1 : 0);
        if (rv) begin
            n = 0;
            if (rel) n = (rc < m_occ) ? rc : m_occ;
            m_occ = m_occ + wr - n;
            m_ep  = (m_ep + wr) % D;
            m_sp  = (m_sp + n) % D;
            case (m_ph)
                0: if (st) begin
                       m_rem = len;
                       m_ph  = (len != 0) ? 1 : 2;
                   end
                1: if (wr == 1) begin
                       m_rem = m_rem - 1;
                       if (m_rem == 0) m_ph = 2;
                   end
                default: m_ph = 0;
            endcase
        end
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) cyc(1'b0, 0, 1'b0, 1'b0, 0, 1'b1);
    endtask

    task automatic do_reset();
        cyc(1'b0, 0, 1'b0, 1'b0, 0, 1'b0);
        cyc(1'b0, 0, 1'b0, 1'b0, 0, 1'b0);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; fill_len = '0; fifo_empty = 1'b1;
        fifo_rdata = '0; release_en = 1'b0; release_cnt = '0;
        model_reset();

        // Reset and basic 3-word fill.
        do_reset();
        cyc(1'b1, 3, 1'b0, 1'b0, 0, 1'b1);
        idle(5);
        check("basic_end_ptr",   end_ptr,   3);
        check("basic_occupancy", occupancy, 3);
        check("basic_start_ptr", start_ptr, 0);

        // FIFO underflow stall in cycles 2-3 of a 4-word burst.
        cyc(1'b1, 4, 1'b0, 1'b0, 0, 1'b1);
        cyc(1'b0, 0, 1'b0, 1'b0, 0, 1'b1);
        cyc(1'b0, 0, 1'b1, 1'b0, 0, 1'b1);
        cyc(1'b0, 0, 1'b1, 1'b0, 0, 1'b1);
        idle(5);
        check("stall_end_ptr", end_ptr, 7);

        // Fill to full with wrap, then a stalled burst freed by a release.
        do_reset();
        cyc(1'b1, 16, 1'b0, 1'b0, 0, 1'b1);
        idle(17);
        check("wrap_full",    full,    1);
        check("wrap_end_ptr", end_ptr, 0);
        cyc(1'b1, 2, 1'b0, 1'b0, 0, 1'b1);
        idle(3);
        cyc(1'b0, 0, 1'b0, 1'b1, 5, 1'b1);
        idle(5);
        check("rel_start_ptr", start_ptr, 5);
        check("rel_occupancy", occupancy, 13);

        // Write and release of 2 together while occupancy is 4.
        do_reset();
        cyc(1'b1, 5, 1'b0, 1'b0, 0, 1'b1);
        idle(4);
        cyc(1'b0, 0, 1'b0, 1'b1, 2, 1'b1);
        idle(1);
        check("simul_occupancy", occupancy, 3);
        idle(2);

        // Release clamp with pointer wrap from start_ptr 14, occupancy 3.
        do_reset();
        cyc(1'b1, 15, 1'b0, 1'b0, 0, 1'b1);
        idle(17);
        cyc(1'b0, 0, 1'b0, 1'b1, 14, 1'b1);
        cyc(1'b1, 2, 1'b0, 1'b0, 0, 1'b1);
        idle(4);
        check("clamp_pre_occ", occupancy, 3);
        cyc(1'b0, 0, 1'b0, 1'b1, 7, 1'b1);
        idle(1);
        check("clamp_start_ptr", start_ptr, 1);
        check("clamp_occupancy", occupancy, 0);
        check("clamp_full",      full,      0);

        // Reset during cycle 2 of a 5-word burst.
        cyc(1'b1, 5, 1'b0, 1'b0, 0, 1'b1);
        cyc(1'b0, 0, 1'b0, 1'b0, 0, 1'b1);
        cyc(1'b0, 0, 1'b0, 1'b0, 0, 1'b0);
        idle(8);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom % 5) == 0,
                int'($urandom % 20),
                ($urandom % 4) == 0,
                ($urandom % 3) == 0,
                (($urandom % 6) == 0) ? int'($urandom % 32) : int'($urandom % 6),
                ($urandom % 250) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
